// File: rtl/inst_queue_predec_if.sv
// Fetch/decode-facing bundle of inst_queue_predec: push lanes from fetch,
// issue slots and pop count towards decode.
interface inst_queue_predec_if #(
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned POP_W  = 2
);
  logic [PUSH_W-1:0]          push_valid;
  logic [PUSH_W*32-1:0]       push_inst;
  logic [PUSH_W*32-1:0]       push_pc;
  logic                       push_ready;
  logic [POP_W-1:0]           out_valid;
  logic [POP_W*32-1:0]        out_inst;
  logic [POP_W*32-1:0]        out_pc;
  logic [POP_W*4-1:0]         out_tag;
  logic [$clog2(POP_W+1)-1:0] pop;

  modport master (
    output push_valid, push_inst, push_pc, pop,
    input  push_ready, out_valid, out_inst, out_pc, out_tag
  );

  modport slave (
    input  push_valid, push_inst, push_pc, pop,
    output push_ready, out_valid, out_inst, out_pc, out_tag
  );
endinterface

// File: rtl/inst_queue_predec.sv
// Instruction queue between fetch and decode with push-time predecode
// tags {is_branch, is_muldiv, is_mem, ri} and issue-pairing rules on the
// presented slots. Optional stall perf counter under macro IQ_PERF_EN.
module inst_queue_predec #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned POP_W  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush_i,
  inst_queue_predec_if.slave           iq,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [31:0]                  stall_cnt_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(PUSH_W+1);
  localparam int unsigned OW = $clog2(POP_W+1);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - PUSH_W);

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [3:0]    tag_q  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          ready_q, push_fire;
  logic [PW-1:0] npush;
  logic [OW-1:0] nvalid, npop;
  logic [POP_W-1:0] valid;
  logic [3:0]    slot_tag [POP_W];
  logic          pair_blk, prev_ok, mem_seen, md_seen, force_ds, cand;

  function automatic logic [3:0] predecode(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic br, mem, md, sup;
    op  = w[31:26];
    rt  = w[20:16];
    fn  = w[5:0];
    br  = (op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000010, 6'b000011})
       || (op == 6'b000001 && rt inside {5'b00000, 5'b00001, 5'b10000, 5'b10001})
       || (op == 6'b000000 && fn inside {6'b001000, 6'b001001});
    mem = (op[5:3] == 3'b100) || (op[5:3] == 3'b101);
    md  = (op == 6'b000000 && fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011})
       || (op == 6'b011100 && fn inside {6'b000010, 6'b000000, 6'b000001, 6'b000100, 6'b000101});
    sup = (op[5:3] == 3'b000) || (op[5:3] == 3'b001)
       || (op inside {6'b010000, 6'b011100, 6'b011111, 6'b101111})
       || (op inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110})
       || (op inside {6'b101000, 6'b101001, 6'b101010, 6'b101011, 6'b101110});
    return {br, md, mem, ~sup};
  endfunction

  // Push acceptance and lane count.
  always_comb begin
    push_fire = ready_q & ~flush_i;
    npush     = '0;
    for (int unsigned i = 0; i < PUSH_W; i++) npush = npush + PW'(iq.push_valid[i]);
  end

  // Slot data view starting at the oldest entry.
  always_comb begin
    iq.out_inst = '0;
    iq.out_pc   = '0;
    iq.out_tag  = '0;
    for (int unsigned k = 0; k < POP_W; k++) begin
      slot_tag[k]              = tag_q[rd_ptr + AW'(k)];
      iq.out_inst[k*32 +: 32]  = inst_q[rd_ptr + AW'(k)];
      iq.out_pc[k*32 +: 32]    = pc_q[rd_ptr + AW'(k)];
      iq.out_tag[k*4 +: 4]     = tag_q[rd_ptr + AW'(k)];
    end
  end

  // Issue prefix: a branch claims its delay slot, which bypasses the pairing checks.
  always_comb begin
    valid    = '0;
    pair_blk = 1'b0;
    prev_ok  = 1'b1;
    mem_seen = 1'b0;
    md_seen  = 1'b0;
    force_ds = 1'b0;
    cand     = 1'b0;
    for (int unsigned k = 0; k < POP_W; k++) begin
      cand = CW'(k) < count;
      if (cand && prev_ok) begin
        if (force_ds) begin
          valid[k] = 1'b1;
          force_ds = 1'b0;
        end else if ((slot_tag[k][1] && mem_seen) || (slot_tag[k][2] && md_seen)) begin
          pair_blk = 1'b1;
        end else if (slot_tag[k][3]) begin
          if ((k + 1 < POP_W) && (CW'(k + 1) < count)) begin
            valid[k] = 1'b1;
            force_ds = 1'b1;
          end
        end else begin
          valid[k] = 1'b1;
        end
      end
      if (valid[k]) begin
        mem_seen = mem_seen | slot_tag[k][1];
        md_seen  = md_seen | slot_tag[k][2];
      end
      prev_ok = valid[k];
    end
  end

  // Clamp the pop request to the issuable prefix and form the next occupancy.
  always_comb begin
    nvalid = '0;
    for (int unsigned k = 0; k < POP_W; k++) nvalid = nvalid + OW'(valid[k]);
    npop       = (iq.pop < nvalid) ? iq.pop : nvalid;
    count_next = count + (push_fire ? CW'(npush) : '0) - CW'(npop);
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      rd_ptr  <= rd_ptr + AW'(npop);
      if (push_fire) wr_ptr <= wr_ptr + AW'(npush);
      count   <= count_next;
      ready_q <= count_next <= READY_MAX;
    end
  end

  // Entry storage with predecode captured at push time.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int unsigned i = 0; i < PUSH_W; i++) begin
        if (iq.push_valid[i]) begin
          inst_q[wr_ptr + AW'(i)] <= iq.push_inst[i*32 +: 32];
          pc_q[wr_ptr + AW'(i)]   <= iq.push_pc[i*32 +: 32];
          tag_q[wr_ptr + AW'(i)]  <= predecode(iq.push_inst[i*32 +: 32]);
        end
      end
    end
  end

  assign iq.out_valid  = valid;
  assign iq.push_ready = ready_q;
  assign count_o       = count;

`ifdef IQ_PERF_EN
  logic [31:0] stall_q;
  // Saturating count of cycles with a waiting branch or a pairing-blocked slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (((count != '0) && !valid[0]) || pair_blk) begin
      if (stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_q;
`else
  logic perf_unused;
  assign perf_unused = pair_blk;
  assign stall_cnt_o = '0;
`endif
endmodule
